// File: rtl/dm_lane_mem.sv
// Byte-lane data memory for the MEM stage; optional alignment exceptions under DM_ALIGN_EXC_EN.
// Latency: loads return registered, extended data with rvalid exactly one cycle after acceptance.
// Backpressure: none once ready=1; requests seen while ready=0 (init sweep) are dropped, requester retries.
module dm_lane_mem #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [3:0]  be,
    input  logic [31:0] wdata,
    input  logic [2:0]  ld_op,
    output logic        ready,
    output logic [31:0] rdata,
`ifdef DM_ALIGN_EXC_EN
    output logic        exc_adel,
    output logic        exc_ades,
`endif
    output logic        rvalid
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [DEPTH_LOG2-1:0] ptr_q, ptr_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  rvalid_q, rvalid_d;
    logic                  adel_q, adel_d;
    logic                  ades_q, ades_d;

    logic [31:0]           mem [DEPTH];

    logic [DEPTH_LOG2-1:0] idx;
    logic [31:0]           rd_word;
    logic [7:0]            rd_byte;
    logic [15:0]           rd_half;
    logic [31:0]           ld_ext;
    logic                  ld_acc, st_acc;
    logic                  ld_err, st_err;
    logic                  wr_en;
    logic [DEPTH_LOG2-1:0] wr_idx;
    logic [31:0]           wr_dat;
    logic [3:0]            wr_be;
    logic                  unused_addr;

    // Address bits above the array wrap silently.
    assign unused_addr = ^{addr[31:DEPTH_LOG2+2]};
    assign idx         = addr[DEPTH_LOG2+1:2];
    assign ready       = (state_q == ST_RUN);
    assign ld_acc      = req & ~we & ready;
    assign st_acc      = req & we & ready;

    always_comb begin
        rd_word = mem[idx];
        case (addr[1:0])
            2'd0:    rd_byte = rd_word[7:0];
            2'd1:    rd_byte = rd_word[15:8];
            2'd2:    rd_byte = rd_word[23:16];
            default: rd_byte = rd_word[31:24];
        endcase
        rd_half = addr[1] ? rd_word[31:16] : rd_word[15:0];
        case (ld_op)
            3'd1:    ld_ext = {24'b0, rd_byte};
            3'd2:    ld_ext = {{24{rd_byte[7]}}, rd_byte};
            3'd3:    ld_ext = {16'b0, rd_half};
            3'd4:    ld_ext = {{16{rd_half[15]}}, rd_half};
            default: ld_ext = rd_word;
        endcase
    end

`ifdef DM_ALIGN_EXC_EN
    always_comb begin
        case (ld_op)
            3'd1, 3'd2: ld_err = 1'b0;
            3'd3, 3'd4: ld_err = addr[0];
            default:    ld_err = (addr[1:0] != 2'b00);
        endcase
        case (be)
            4'b1111, 4'b0011, 4'b1100,
            4'b0001, 4'b0010, 4'b0100, 4'b1000: st_err = 1'b0;
            default:                            st_err = 1'b1;
        endcase
    end
    assign exc_adel = adel_q;
    assign exc_ades = ades_q;
`else
    assign ld_err = 1'b0;
    assign st_err = 1'b0;
`endif

    // The sweep owns the write port while in INIT; requests are not accepted then anyway.
    always_comb begin
        wr_en  = 1'b0;
        wr_idx = idx;
        wr_dat = wdata;
        wr_be  = be;
        if (state_q == ST_INIT) begin
            wr_en  = 1'b1;
            wr_idx = ptr_q;
            wr_dat = 32'h0;
            wr_be  = 4'b1111;
        end else if (st_acc && !st_err) begin
            wr_en  = 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        rdata_d  = rdata_q;
        rvalid_d = ld_acc;
        adel_d   = ld_acc & ld_err;
        ades_d   = st_acc & st_err;
        if (state_q == ST_INIT) begin
            ptr_d = ptr_q + 1'b1;
            if (&ptr_q) begin
                state_d = ST_RUN;
            end
        end
        if (ld_acc) begin
            rdata_d = ld_err ? 32'h0 : ld_ext;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_INIT;
            ptr_q    <= '0;
            rdata_q  <= 32'h0;
            rvalid_q <= 1'b0;
            adel_q   <= 1'b0;
            ades_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            adel_q   <= adel_d;
            ades_q   <= ades_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i]) begin
                    mem[wr_idx][8*i +: 8] <= wr_dat[8*i +: 8];
                end
            end
        end
    end

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;

endmodule

// File: tb/tb_dm_lane_mem.sv
// Directed bench for dm_lane_mem at DEPTH_LOG2=4: vector table for single-cycle accesses,
// hand sequences for the init sweep, reset aborts, store/load alternation and alignment errors.
module tb_dm_lane_mem;

    localparam int DL2 = 4;
`ifdef DM_ALIGN_EXC_EN
    localparam bit EXC = 1'b1;
`else
    localparam bit EXC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        req, we;
    logic [31:0] addr, wdata;
    logic [3:0]  be;
    logic [2:0]  ld_op;
    logic        ready, rvalid;
    logic [31:0] rdata;
`ifdef DM_ALIGN_EXC_EN
    logic        exc_adel, exc_ades;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dm_lane_mem #(.DEPTH_LOG2(DL2)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .we       (we),
        .addr     (addr),
        .be       (be),
        .wdata    (wdata),
        .ld_op    (ld_op),
        .ready    (ready),
        .rdata    (rdata),
`ifdef DM_ALIGN_EXC_EN
        .exc_adel (exc_adel),
        .exc_ades (exc_ades),
`endif
        .rvalid   (rvalid)
    );

    typedef struct {
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [2:0]  op;
        logic        e_vld;
        logic [31:0] e_dat;
        logic        chk_dat;
        logic        e_ades;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic r, input logic w, input logic [31:0] a, input logic [3:0] b,
                       input logic [31:0] d, input logic [2:0] op);
        req = r; we = w; addr = a; be = b; wdata = d; ld_op = op;
    endtask

    task automatic idle();
        drv(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 3'd0);
    endtask

    function automatic vec_t mk(input logic r, input logic w, input logic [31:0] a, input logic [3:0] b,
                                input logic [31:0] d, input logic [2:0] op, input logic ev,
                                input logic [31:0] ed, input logic cd, input logic es);
        vec_t v;
        v.req = r; v.we = w; v.addr = a; v.be = b; v.wdata = d; v.op = op;
        v.e_vld = ev; v.e_dat = ed; v.chk_dat = cd; v.e_ades = es;
        return v;
    endfunction

    // Loads (ld_op 0..4) check rdata; stores check only that rvalid stays low.
    task automatic ld(input string nm, input logic [31:0] a, input logic [2:0] op, input logic [31:0] exp);
        drv(1'b1, 1'b0, a, 4'h0, 32'h0, op);
        tick();
        idle();
        chk({nm, " rvalid"}, rvalid, 1'b1);
        chk({nm, " rdata"}, rdata, exp);
    endtask

    task automatic st(input string nm, input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
        drv(1'b1, 1'b1, a, b, d, 3'd0);
        tick();
        idle();
        chk({nm, " rvalid"}, rvalid, 1'b0);
    endtask

    initial begin
        int cnt;
        logic [31:0] d;

        // Single-cycle access table.
        tbl.push_back(mk(1, 1, 32'h10, 4'hF, 32'h8000_F0A5, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 32'h10, 4'h0, 0, 2, 1, 32'hFFFF_FFA5, 1, 0));
        tbl.push_back(mk(1, 0, 32'h11, 4'h0, 0, 1, 1, 32'h0000_00F0, 1, 0));
        tbl.push_back(mk(1, 0, 32'h12, 4'h0, 0, 4, 1, 32'hFFFF_8000, 1, 0));
        tbl.push_back(mk(1, 0, 32'h12, 4'h0, 0, 3, 1, 32'h0000_8000, 1, 0));
        tbl.push_back(mk(1, 0, 32'h10, 4'h0, 0, 0, 1, 32'h8000_F0A5, 1, 0));
        tbl.push_back(mk(1, 0, 32'h10, 4'h0, 0, 7, 1, 32'h8000_F0A5, 1, 0));
        tbl.push_back(mk(0, 0, 32'h10, 4'h0, 0, 0, 0, 32'h8000_F0A5, 1, 0));
        tbl.push_back(mk(1, 1, 32'h20, 4'hF, 32'h1122_3344, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 32'h20, 4'h4, 32'h00AA_0000, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 32'h20, 4'h0, 0, 0, 1, 32'h11AA_3344, 1, 0));
        tbl.push_back(mk(1, 1, 32'h20, 4'h0, 32'hFFFF_FFFF, 0, 0, 32'h11AA_3344, 1, EXC));
        tbl.push_back(mk(1, 0, 32'h20, 4'h0, 0, 0, 1, 32'h11AA_3344, 1, 0));
        tbl.push_back(mk(1, 0, 32'h23, 4'h0, 0, 2, 1, 32'h0000_0011, 1, 0));
        tbl.push_back(mk(1, 0, 32'h20, 4'h0, 0, 4, 1, 32'h0000_3344, 1, 0));
        tbl.push_back(mk(1, 0, 32'h22, 4'h0, 0, 1, 1, 32'h0000_00AA, 1, 0));
        tbl.push_back(mk(1, 0, 32'h22, 4'h0, 0, 2, 1, 32'hFFFF_FFAA, 1, 0));
        tbl.push_back(mk(1, 0, 32'h60, 4'h0, 0, 0, 1, 32'h11AA_3344, 1, 0));
        tbl.push_back(mk(1, 0, 32'hFFFF_FF20, 4'h0, 0, 0, 1, 32'h11AA_3344, 1, 0));

        // Reset state and the first init sweep.
        idle();
        reset = 1'b1;
        #2 reset = 1'b0;
        #1;
        chk("rst ready", ready, 1'b0);
        chk("rst rvalid", rvalid, 1'b0);
        chk("rst rdata", rdata, 32'h0);
        tick();
        tick();
        reset = 1'b1;
        cnt = 0;
        while (!ready && cnt < 100) begin
            tick();
            cnt++;
        end
        chk("init sweep length", cnt, 32'd16);
        for (int i = 0; i < 16; i++) begin
            drv(1'b1, 1'b0, 32'(i * 4), 4'h0, 32'h0, 3'd0);
            tick();
            chk($sformatf("init lw w%0d rvalid", i), rvalid, 1'b1);
            chk($sformatf("init lw w%0d rdata", i), rdata, 32'h0);
        end
        idle();
        tick();
        chk("pulse end rvalid", rvalid, 1'b0);

        // Table vectors: request before the edge, registered response just after it.
        for (int i = 0; i < tbl.size(); i++) begin
            drv(tbl[i].req, tbl[i].we, tbl[i].addr, tbl[i].be, tbl[i].wdata, tbl[i].op);
            tick();
            chk($sformatf("vec%0d rvalid", i), rvalid, tbl[i].e_vld);
            if (tbl[i].chk_dat) chk($sformatf("vec%0d rdata", i), rdata, tbl[i].e_dat);
`ifdef DM_ALIGN_EXC_EN
            chk($sformatf("vec%0d exc_ades", i), exc_ades, tbl[i].e_ades);
            chk($sformatf("vec%0d exc_adel", i), exc_adel, 1'b0);
`endif
        end
        idle();

        // Misaligned accesses and a non-contiguous byte enable.
`ifdef DM_ALIGN_EXC_EN
        drv(1'b1, 1'b0, 32'h22, 4'h0, 32'h0, 3'd0);
        tick();
        chk("lw mis rvalid", rvalid, 1'b1);
        chk("lw mis adel", exc_adel, 1'b1);
        chk("lw mis rdata", rdata, 32'h0);
        drv(1'b1, 1'b0, 32'h21, 4'h0, 32'h0, 3'd4);
        tick();
        chk("lh mis adel", exc_adel, 1'b1);
        chk("lh mis rdata", rdata, 32'h0);
        drv(1'b1, 1'b0, 32'h23, 4'h0, 32'h0, 3'd3);
        tick();
        chk("lhu mis adel", exc_adel, 1'b1);
        drv(1'b1, 1'b0, 32'h23, 4'h0, 32'h0, 3'd2);
        tick();
        chk("lb odd adel", exc_adel, 1'b0);
        chk("lb odd rdata", rdata, 32'h0000_0011);
        drv(1'b1, 1'b1, 32'h20, 4'b0110, 32'hFFFF_FFFF, 3'd0);
        tick();
        idle();
        chk("be0110 ades", exc_ades, 1'b1);
        chk("be0110 rvalid", rvalid, 1'b0);
        tick();
        chk("ades pulse end", exc_ades, 1'b0);
        ld("be0110 unchanged", 32'h20, 3'd0, 32'h11AA_3344);
        chk("aligned lw adel", exc_adel, 1'b0);
`else
        ld("lw mis", 32'h22, 3'd0, 32'h11AA_3344);
        ld("lh mis", 32'h21, 3'd4, 32'h0000_3344);
        ld("lhu mis", 32'h23, 3'd3, 32'h0000_11AA);
        st("be0110", 32'h20, 4'b0110, 32'hFFFF_FFFF);
        ld("be0110 result", 32'h20, 3'd0, 32'h11FF_FF44);
`endif

        // Alternating store/load to one address with fresh data each pair.
        for (int i = 0; i < 4; i++) begin
            d = 32'hA5A5_0000 ^ (32'(i + 1) * 32'h0101_1111);
            st($sformatf("alt sw%0d", i), 32'h34, 4'hF, d);
            ld($sformatf("alt lw%0d", i), 32'h34, 3'd0, d);
        end
        tick();
        chk("alt pulse end", rvalid, 1'b0);

        // Reset asserted with a load response in flight.
        drv(1'b1, 1'b0, 32'h10, 4'h0, 32'h0, 3'd0);
        tick();
        idle();
        chk("pre-abort rdata", rdata, 32'h8000_F0A5);
        reset = 1'b0;
        #1;
        chk("abort ready", ready, 1'b0);
        chk("abort rvalid", rvalid, 1'b0);
        chk("abort rdata", rdata, 32'h0);
        tick();
        reset = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        #2 reset = 1'b0;
        #1;
        chk("mid-sweep reset ready", ready, 1'b0);
        tick();
        reset = 1'b1;

        // Restarted sweep: full length again, with requests ignored throughout.
        cnt = 0;
        while (!ready && cnt < 100) begin
            drv(1'b1, cnt[0] == 1'b0, 32'h0, 4'hF, 32'hDEAD_BEEF, 3'd0);
            tick();
            cnt++;
            chk($sformatf("sweep req %0d rvalid", cnt), rvalid, 1'b0);
        end
        idle();
        chk("restart sweep length", cnt, 32'd16);
        ld("ignored sw w0", 32'h0, 3'd0, 32'h0);
        ld("cleared w4", 32'h10, 3'd0, 32'h0);
        ld("cleared w8", 32'h20, 3'd0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
